hall_snapshot_ctrl: RTL and testbench

HALL_SNAPSHOT_CTRL -- requirements
Module: hall_snapshot_ctrl

---
 rtl/hall_snapshot_ctrl_pkg.sv | 21 ++
 rtl/hall_snapshot_ctrl_if.sv | 29 ++
 rtl/hall_snapshot_ctrl_timer.sv | 32 +++
 rtl/hall_snapshot_ctrl.sv | 134 +++++++++++++
 tb/tb_hall_snapshot_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hall_snapshot_ctrl_pkg.sv
// Shared types for the hall counter snapshot controller: FSM encoding,
// the 8-bit signed step-delta type and the modulo delta helper.
package hall_snapshot_ctrl_pkg;

  typedef logic [7:0] delta_t;
  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_STREAM  = 2'd2;

  localparam int CHAN_W = 3;

  // Modulo-256 difference; reading the result as two's complement gives the
  // signed step count across a counter wrap.
  function automatic delta_t step_delta(input logic [7:0] now_cnt,
                                        input logic [7:0] prev_cnt);
    return delta_t'(now_cnt - prev_cnt);
  endfunction

endpackage

// File: rtl/hall_snapshot_ctrl_if.sv
// Snapshot output stream: one delta word per channel, with a last marker.
interface hall_snapshot_ctrl_if;
  import hall_snapshot_ctrl_pkg::*;

  // A word transfers on a clock edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_data/out_chan/out_last hold.
  delta_t      out_data;
  logic [2:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output out_data,
    output out_chan,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_chan,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/hall_snapshot_ctrl_timer.sv
// Free-running auto-snapshot timer: one-cycle tick every PERIOD cycles,
// never ticks when PERIOD is 0.
module snapshot_timer #(
  parameter int unsigned PERIOD = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
  localparam logic [CW-1:0] LAST = (PERIOD > 0) ? CW'(PERIOD - 1) : '0;
  localparam logic ENABLE = (PERIOD > 0);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = ENABLE & w_at_last;

endmodule

// File: rtl/hall_snapshot_ctrl.sv
// Hall counter snapshot controller: on a request or timer tick, latch the
// per-channel step deltas and stream them out one channel per word.
module hall_snapshot_ctrl
  import hall_snapshot_ctrl_pkg::*;
#(
  parameter int          NUM_MOTORS = 5,
  parameter int unsigned PERIOD     = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*NUM_MOTORS-1:0] counts,
  input  logic                    snap_req,
  input  logic                    overrun_clr,
  output logic                    overrun,
  output logic [1:0]              o_dbg_state,
  hall_snapshot_ctrl_if.master    out_if
);

  localparam logic [CHAN_W-1:0] LAST_CHAN  = CHAN_W'(NUM_MOTORS - 1);
  localparam logic              SINGLE_CHN = (NUM_MOTORS == 1);

  state_t            r_state;
  delta_t            r_prev  [NUM_MOTORS];
  delta_t            r_delta [NUM_MOTORS];
  delta_t            r_out_data;
  logic [CHAN_W-1:0] r_out_chan;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_overrun;

  logic              w_tick;
  logic              w_trigger;
  logic              w_xfer;
  logic [CHAN_W-1:0] w_next_chan;
  delta_t            w_next_data;
  delta_t            w_delta_new [NUM_MOTORS];

  snapshot_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .i_clk  (clk),
    .i_rst  (reset),
    .o_tick (w_tick)
  );

  // A request and a tick in the same cycle are a single trigger.
  assign w_trigger   = snap_req | w_tick;
  assign w_xfer      = r_out_valid & out_if.out_ready;
  assign w_next_chan = r_out_chan + 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_MOTORS; i++) begin
      w_delta_new[i] = step_delta(counts[8*i +: 8], r_prev[i]);
    end
  end

  always_comb begin
    w_next_data = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (w_next_chan == CHAN_W'(i)) begin
        w_next_data = r_delta[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        r_prev[i]  <= '0;
        r_delta[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // The only place counts are sampled; later changes wait for the next snapshot.
          for (int i = 0; i < NUM_MOTORS; i++) begin
            r_delta[i] <= w_delta_new[i];
            r_prev[i]  <= counts[8*i +: 8];
          end
          r_out_chan  <= '0;
          r_out_data  <= w_delta_new[0];
          r_out_last  <= SINGLE_CHN;
          r_out_valid <= 1'b1;
          r_state     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_xfer) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_out_chan <= w_next_chan;
              r_out_data <= w_next_data;
              r_out_last <= (w_next_chan == LAST_CHAN);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Triggers outside IDLE are dropped, including on the final transfer; set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_trigger && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign out_if.out_data  = r_out_data;
  assign out_if.out_chan  = r_out_chan;
  assign out_if.out_valid = r_out_valid;
  assign out_if.out_last  = r_out_last;
  assign overrun          = r_overrun;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_hall_snapshot_ctrl.sv
// Directed bench for hall_snapshot_ctrl: a manual-trigger instance (timer off)
// and an auto-timer instance with PERIOD=20.
module tb_hall_snapshot_ctrl;
  import hall_snapshot_ctrl_pkg::*;

  localparam int NM = 5;

  logic          clk;
  logic          rst_a, rst_b;
  logic [8*NM-1:0] counts_a, counts_b;
  logic          snap_a, snap_b;
  logic          clr_a, clr_b;
  logic          overrun_a, overrun_b;
  logic [1:0]    state_a, state_b;

  hall_snapshot_ctrl_if if_a ();
  hall_snapshot_ctrl_if if_b ();

  hall_snapshot_ctrl #(.NUM_MOTORS(NM), .PERIOD(0)) dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .counts      (counts_a),
    .snap_req    (snap_a),
    .overrun_clr (clr_a),
    .overrun     (overrun_a),
    .o_dbg_state (state_a),
    .out_if      (if_a.master)
  );

  hall_snapshot_ctrl #(.NUM_MOTORS(NM), .PERIOD(20)) dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .counts      (counts_b),
    .snap_req    (snap_b),
    .overrun_clr (clr_b),
    .overrun     (overrun_b),
    .o_dbg_state (state_b),
    .out_if      (if_b.master)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic set_counts_a(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] c3, input logic [7:0] c4);
    counts_a = {c4, c3, c2, c1, c0};
  endtask

  task automatic push_exp(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [7:0] d3, input logic [7:0] d4);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
    exp_q.push_back(d4);
  endtask

  // Pulse snap_req from a negedge; returns at the negedge where word 0 should be valid.
  task automatic trigger_snapshot();
    snap_a = 1'b1;
    @(negedge clk);
    snap_a = 1'b0;
    check("lat_capture_valid", if_a.out_valid, 0);
    check("lat_capture_state", state_a, ST_CAPTURE);
    @(negedge clk);
  endtask

  task automatic expect_stream(input bit stall_ch2, input int snap_at, input int clr_at);
    logic [7:0] exp_d;
    for (int i = 0; i < NM; i++) begin
      exp_d = exp_q.pop_front();
      check("word_valid", if_a.out_valid, 1);
      check("word_chan", if_a.out_chan, i);
      check("word_data", if_a.out_data, exp_d);
      check("word_last", if_a.out_last, (i == NM - 1));
      if (stall_ch2 && i == 2) begin
        if_a.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_valid", if_a.out_valid, 1);
          check("stall_chan", if_a.out_chan, 2);
          check("stall_data", if_a.out_data, exp_d);
          check("stall_last", if_a.out_last, 0);
        end
        if_a.out_ready = 1'b1;
      end
      snap_a = (i == snap_at);
      clr_a  = (i == clr_at);
      @(negedge clk);
      snap_a = 1'b0;
      clr_a  = 1'b0;
    end
    check("end_valid", if_a.out_valid, 0);
    check("end_state", state_a, ST_IDLE);
  endtask

  task automatic expect_quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      check("quiet_valid", if_a.out_valid, 0);
      check("quiet_state", state_a, ST_IDLE);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    snap_a = 1'b0;
    snap_b = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    counts_a = '0;
    counts_b = {NM{8'h07}};
    if_a.out_ready = 1'b1;
    if_b.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", if_a.out_valid, 0);
    check("rst_data", if_a.out_data, 0);
    check("rst_chan", if_a.out_chan, 0);
    check("rst_last", if_a.out_last, 0);
    check("rst_overrun", overrun_a, 0);
    check("rst_state", state_a, ST_IDLE);
    rst_a = 1'b0;

    // Basic snapshot: all counts 0x10 relative to 0
    set_counts_a(8'h10, 8'h10, 8'h10, 8'h10, 8'h10);
    repeat (3) @(negedge clk);
    push_exp(8'h10, 8'h10, 8'h10, 8'h10, 8'h10);
    trigger_snapshot();
    expect_stream(0, -1, -1);

    // Mixed deltas including a backward wrap
    set_counts_a(8'hFE, 8'h20, 8'h0F, 8'h10, 8'h90);
    push_exp(8'hEE, 8'h10, 8'hFF, 8'h00, 8'h80);
    trigger_snapshot();
    expect_stream(0, -1, -1);

    // Forward wrap 0xFE -> 0x03 gives +5
    set_counts_a(8'h03, 8'h25, 8'h0F, 8'h11, 8'h90);
    push_exp(8'h05, 8'h05, 8'h00, 8'h01, 8'h00);
    trigger_snapshot();
    expect_stream(0, -1, -1);

    // Backward wrap 0x03 -> 0xFE gives -5, backpressure on ch2, counts moving mid-stream
    set_counts_a(8'hFE, 8'h25, 8'h0F, 8'h11, 8'h90);
    push_exp(8'hFB, 8'h00, 8'h00, 8'h00, 8'h00);
    trigger_snapshot();
    set_counts_a(8'hFE, 8'h30, 8'h0F, 8'h11, 8'h90);
    expect_stream(1, -1, -1);
    check("ovr_before", overrun_a, 0);

    // Request during STREAM: dropped, overrun set, mid-stream count change shows now
    push_exp(8'h00, 8'h0B, 8'h00, 8'h00, 8'h00);
    trigger_snapshot();
    expect_stream(0, 1, -1);
    check("ovr_stream_set", overrun_a, 1);
    expect_quiet(4);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("ovr_cleared", overrun_a, 0);

    // Request on the final transfer is also dropped
    push_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    trigger_snapshot();
    expect_stream(0, NM - 1, -1);
    check("ovr_last_set", overrun_a, 1);
    expect_quiet(3);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check("ovr_cleared2", overrun_a, 0);

    // Set wins over a coincident clear
    push_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    trigger_snapshot();
    expect_stream(0, 2, 2);
    check("ovr_set_wins", overrun_a, 1);

    // Reset during STREAM on channel 3
    set_counts_a(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    trigger_snapshot();
    repeat (3) @(negedge clk);
    check("abort_pre_chan", if_a.out_chan, 3);
    check("abort_pre_data", if_a.out_data, 8'h33);
    rst_a = 1'b1;
    #1;
    check("abort_valid", if_a.out_valid, 0);
    check("abort_data", if_a.out_data, 0);
    check("abort_chan", if_a.out_chan, 0);
    check("abort_last", if_a.out_last, 0);
    check("abort_overrun", overrun_a, 0);
    check("abort_state", state_a, ST_IDLE);
    @(negedge clk);
    rst_a = 1'b0;
    expect_quiet(3);
    push_exp(8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
    trigger_snapshot();
    expect_stream(0, -1, -1);

    // Auto timer, PERIOD=20: trigger sampled at edges 20, 40, 60
    rst_b = 1'b0;
    for (int m = 1; m <= 65; m++) begin
      int ph;
      bit exp_valid;
      @(negedge clk);
      ph = m % 20;
      exp_valid = (m >= 21) && (ph >= 1) && (ph <= 5);
      check("tmr_valid", if_b.out_valid, exp_valid);
      if (exp_valid) begin
        check("tmr_chan", if_b.out_chan, ph - 1);
        check("tmr_data", if_b.out_data, (m < 40) ? 8'h07 : 8'h00);
        check("tmr_last", if_b.out_last, (ph == 5));
      end
    end
    check("tmr_overrun", overrun_b, 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
